frog_controller: RTL and testbench

- Upstream neighbour of the colour mapper. Produces the frog sprite centre and size (FrogX, FrogY, FrogS) that the mapper draws.
- Converts USB keyboard keycodes into grid-aligned hops. Animates each hop over several frames, and handles death, respawn and goal detection.
- All state advances on frame ticks derived from the VGA vertical-sync frame clock.

---
 rtl/frog_pkg.sv | 33 +++
 rtl/frog_controller_frame_tick_sync.sv | 29 ++
 rtl/frog_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_frog_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared types, keycodes and key decode for the frog controller.
package frog_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOP  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    function automatic dir_t key_to_dir(input logic [7:0] key);
        case (key)
            KEY_W:   return UP;
            KEY_S:   return DOWN;
            KEY_A:   return LEFT;
            KEY_D:   return RIGHT;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/frog_controller_frame_tick_sync.sv
// Brings the vsync-derived frame clock into the Clk domain and emits a
// one-cycle pulse per rising edge.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_clk_i,
    output logic frame_tick_o
);

    logic sync1_q;
    logic sync2_q;
    logic edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    // State in the parent advances on the third Clk edge after the frame_clk edge.
    assign frame_tick_o = sync2_q & ~edge_q;

endmodule

// File: rtl/frog_controller.sv
// Frog position controller: keycode hops on a grid, death/respawn and goal.
// Define HOP_QUEUE_EN to buffer the first press seen during a hop.
module frog_controller
    import frog_pkg::*;
#(
    parameter int CELL         = 32,
    parameter int HOP_STEP     = 4,
    parameter int START_X      = 336,
    parameter int START_Y      = 464,
    parameter int X_MIN        = 16,
    parameter int X_MAX        = 624,
    parameter int Y_MIN        = 16,
    parameter int Y_MAX        = 464,
    parameter int FROG_SIZE    = 12,
    parameter int DEATH_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic [9:0] FrogX,
    output logic [9:0] FrogY,
    output logic [9:0] FrogS,
    output logic       hopping,
    output logic       frog_dead,
    output logic       goal_pulse
);

    localparam int STEPS = CELL / HOP_STEP;

    logic       frame_tick;
    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    dir_t       prev_q, prev_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] step_q, step_d;
    logic [7:0] dead_q, dead_d;
    logic       hit_q, hit_d;
    logic       goal_q, goal_d;
`ifdef HOP_QUEUE_EN
    dir_t       queue_q, queue_d;
`endif

    dir_t       cur_dir;
    dir_t       start_dir;
    logic       press;
    logic       hit_now;

    frame_tick_sync u_sync (
        .clk_i        (Clk),
        .rst_ni       (Reset),
        .frame_clk_i  (frame_clk),
        .frame_tick_o (frame_tick)
    );

    // Widen to 11 bits so a move off the low edge goes negative instead of wrapping.
    function automatic logic dir_legal(input dir_t d, input logic [9:0] x, input logic [9:0] y);
        logic signed [10:0] tx;
        logic signed [10:0] ty;
        tx = $signed({1'b0, x});
        ty = $signed({1'b0, y});
        case (d)
            UP:      ty = ty - $signed(11'(CELL));
            DOWN:    ty = ty + $signed(11'(CELL));
            LEFT:    tx = tx - $signed(11'(CELL));
            RIGHT:   tx = tx + $signed(11'(CELL));
            default: ;
        endcase
        return (d != NONE) &&
               (tx >= $signed(11'(X_MIN))) && (tx <= $signed(11'(X_MAX))) &&
               (ty >= $signed(11'(Y_MIN))) && (ty <= $signed(11'(Y_MAX)));
    endfunction

    function automatic logic [9:0] move_x(input dir_t d, input logic [9:0] x);
        case (d)
            LEFT:    return x - 10'(HOP_STEP);
            RIGHT:   return x + 10'(HOP_STEP);
            default: return x;
        endcase
    endfunction

    function automatic logic [9:0] move_y(input dir_t d, input logic [9:0] y);
        case (d)
            UP:      return y - 10'(HOP_STEP);
            DOWN:    return y + 10'(HOP_STEP);
            default: return y;
        endcase
    endfunction

    assign cur_dir = key_to_dir(keycode);
    assign press   = (cur_dir != NONE) && (cur_dir != prev_q);
    assign hit_now = hit_q | hit;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        prev_d    = prev_q;
        x_d       = x_q;
        y_d       = y_q;
        step_d    = step_q;
        dead_d    = dead_q;
        goal_d    = 1'b0;
        start_dir = NONE;
        hit_d     = (state_q == DEAD) ? 1'b0 : hit_now;
`ifdef HOP_QUEUE_EN
        queue_d   = queue_q;
`endif
        if (frame_tick) begin
            prev_d = cur_dir;
            hit_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (hit_now) begin
                        state_d = DEAD;
                        dead_d  = 8'(DEATH_FRAMES - 1);
`ifdef HOP_QUEUE_EN
                        queue_d = NONE;
`endif
                    end else begin
`ifdef HOP_QUEUE_EN
                        if (queue_q != NONE) begin
                            start_dir = queue_q;
                            queue_d   = NONE;
                        end else if (press) begin
                            start_dir = cur_dir;
                        end
`else
                        if (press) start_dir = cur_dir;
`endif
                        if (dir_legal(start_dir, x_q, y_q)) begin
                            state_d = HOP;
                            dir_d   = start_dir;
                            step_d  = 8'(STEPS - 1);
                            x_d     = move_x(start_dir, x_q);
                            y_d     = move_y(start_dir, y_q);
                        end
                    end
                end
                HOP: begin
                    if (hit_now) begin
                        state_d = DEAD;
                        dead_d  = 8'(DEATH_FRAMES - 1);
`ifdef HOP_QUEUE_EN
                        queue_d = NONE;
`endif
                    end else if (step_q == 8'd0) begin
                        state_d = IDLE;
                        if (y_q == 10'(Y_MIN)) begin
                            x_d    = 10'(START_X);
                            y_d    = 10'(START_Y);
                            goal_d = 1'b1;
`ifdef HOP_QUEUE_EN
                            queue_d = NONE;
`endif
                        end
`ifdef HOP_QUEUE_EN
                        else if (!dir_legal(queue_q, x_q, y_q)) begin
                            queue_d = NONE;
                        end
`endif
                    end else begin
                        x_d    = move_x(dir_q, x_q);
                        y_d    = move_y(dir_q, y_q);
                        step_d = step_q - 8'd1;
`ifdef HOP_QUEUE_EN
                        if (press && queue_q == NONE) queue_d = cur_dir;
`endif
                    end
                end
                DEAD: begin
                    if (dead_q == 8'd0) begin
                        state_d = IDLE;
                        x_d     = 10'(START_X);
                        y_d     = 10'(START_Y);
                    end else begin
                        dead_d = dead_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            prev_q  <= NONE;
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            step_q  <= 8'd0;
            dead_q  <= 8'd0;
            hit_q   <= 1'b0;
            goal_q  <= 1'b0;
`ifdef HOP_QUEUE_EN
            queue_q <= NONE;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            prev_q  <= prev_d;
            x_q     <= x_d;
            y_q     <= y_d;
            step_q  <= step_d;
            dead_q  <= dead_d;
            hit_q   <= hit_d;
            goal_q  <= goal_d;
`ifdef HOP_QUEUE_EN
            queue_q <= queue_d;
`endif
        end
    end

    assign FrogX      = x_q;
    assign FrogY      = y_q;
    assign FrogS      = 10'(FROG_SIZE);
    assign hopping    = (state_q == HOP);
    assign frog_dead  = (state_q == DEAD);
    assign goal_pulse = goal_q;

endmodule

// File: tb/tb_frog_controller.sv
// Bench for frog_controller: directed scenarios plus random keys and hits,
// checked against a per-frame behavioural model of the frog.
module tb_frog_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       hit = 1'b0;
    logic [9:0] FrogX, FrogY, FrogS;
    logic       hopping, frog_dead, goal_pulse;

`ifdef HOP_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    frog_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .hit        (hit),
        .FrogX      (FrogX),
        .FrogY      (FrogY),
        .FrogS      (FrogS),
        .hopping    (hopping),
        .frog_dead  (frog_dead),
        .goal_pulse (goal_pulse)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int goal_cycles = 0;

    always @(negedge Clk) if (goal_pulse === 1'b1) goal_cycles++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: mode 0=idle 1=hop 2=dead; directions 0 none 1 up 2 down 3 left 4 right.
    int  mx, my, mtx, mty, mmode, mprev, mq, mdead, mgoals;
    bit  mhit;

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 1;
            8'h16:   return 2;
            8'h04:   return 3;
            8'h07:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int tgt_x(input int d, input int x);
        return (d == 3) ? x - 32 : (d == 4) ? x + 32 : x;
    endfunction

    function automatic int tgt_y(input int d, input int y);
        return (d == 1) ? y - 32 : (d == 2) ? y + 32 : y;
    endfunction

    function automatic bit legal(input int d, input int x, input int y);
        int tx, ty;
        tx = tgt_x(d, x);
        ty = tgt_y(d, y);
        return d != 0 && tx >= 16 && tx <= 624 && ty >= 16 && ty <= 464;
    endfunction

    task automatic model_reset();
        mx = 336; my = 464; mtx = 336; mty = 464;
        mmode = 0; mprev = 0; mq = 0; mdead = 0; mhit = 1'b0;
    endtask

    task automatic step_toward();
        if (mx < mtx) mx += 4; else if (mx > mtx) mx -= 4;
        if (my < mty) my += 4; else if (my > mty) my -= 4;
    endtask

    task automatic model_tick(input logic [7:0] k);
        int d, sd;
        bit press, hv;
        d = key_dir(k);
        press = (d != 0) && (d != mprev);
        mprev = d;
        hv = mhit;
        mhit = 1'b0;
        case (mmode)
            0: begin
                if (hv) begin
                    mmode = 2; mdead = 30; mq = 0;
                end else begin
                    sd = 0;
                    if (QEN && mq != 0) begin sd = mq; mq = 0; end
                    else if (press) sd = d;
                    if (legal(sd, mx, my)) begin
                        mmode = 1;
                        mtx = tgt_x(sd, mx);
                        mty = tgt_y(sd, my);
                        step_toward();
                    end
                end
            end
            1: begin
                if (hv) begin
                    mmode = 2; mdead = 30; mq = 0;
                end else if (mx == mtx && my == mty) begin
                    mmode = 0;
                    if (my == 16) begin
                        mx = 336; my = 464; mgoals++; mq = 0;
                    end else if (mq != 0 && !legal(mq, mx, my)) begin
                        mq = 0;
                    end
                end else begin
                    step_toward();
                    if (QEN && press && mq == 0) mq = d;
                end
            end
            default: begin
                mdead--;
                if (mdead == 0) begin
                    mmode = 0; mx = 336; my = 464;
                end
            end
        endcase
    endtask

    task automatic do_tick(input bit chk_lat);
        @(negedge Clk);
        frame_clk = 1'b1;
        if (chk_lat) begin
            @(posedge Clk); @(posedge Clk); #1;
            check_eq("tick_latency_before", int'(hopping), 0);
            @(posedge Clk); #1;
            check_eq("tick_latency_after", int'(hopping), 1);
        end
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        model_tick(keycode);
        check_eq("frog_x", int'(FrogX), mx);
        check_eq("frog_y", int'(FrogY), my);
        check_eq("hopping", int'(hopping), int'(mmode == 1));
        check_eq("frog_dead", int'(frog_dead), int'(mmode == 2));
        check_eq("goal_count", goal_cycles, mgoals);
    endtask

    task automatic pulse_hit();
        @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        if (mmode != 2) mhit = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        keycode = 8'h00;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic hop_once(input logic [7:0] k);
        keycode = 8'h00;
        do_tick(1'b0);
        keycode = k;
        do_tick(1'b0);
        keycode = 8'h00;
        repeat (8) do_tick(1'b0);
    endtask

    int hop_ticks, hop_starts, dead_ticks, gbase, prev_h;
    logic [7:0] keys [6];

    initial begin
        keys[0] = 8'h00; keys[1] = 8'h1A; keys[2] = 8'h16;
        keys[3] = 8'h04; keys[4] = 8'h07; keys[5] = 8'h55;
        mgoals = 0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_eq("reset_x", int'(FrogX), 336);
        check_eq("reset_y", int'(FrogY), 464);
        check_eq("reset_s", int'(FrogS), 12);
        check_eq("reset_hopping", int'(hopping), 0);
        check_eq("reset_dead", int'(frog_dead), 0);
        check_eq("reset_goal", int'(goal_pulse), 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Hold LEFT for 20 ticks: exactly one hop of 8 frames.
        keycode = 8'h04;
        hop_ticks = 0; hop_starts = 0; prev_h = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick(i == 0);
            if (hopping) hop_ticks++;
            if (hopping && prev_h == 0) hop_starts++;
            prev_h = int'(hopping);
        end
        check_eq("hold_hop_ticks", hop_ticks, 8);
        check_eq("hold_hop_starts", hop_starts, 1);
        check_eq("hold_final_x", int'(FrogX), 304);

        // Walk to the left edge, then a further LEFT must be refused.
        repeat (9) hop_once(8'h04);
        check_eq("edge_x", int'(FrogX), 16);
        keycode = 8'h00; do_tick(1'b0);
        keycode = 8'h04; do_tick(1'b0);
        check_eq("edge_no_hop", int'(hopping), 0);
        keycode = 8'h00;
        repeat (2) do_tick(1'b0);
        check_eq("edge_x_hold", int'(FrogX), 16);

        // Fourteen UP hops reach the goal row and respawn.
        do_reset();
        gbase = goal_cycles;
        repeat (14) hop_once(8'h1A);
        check_eq("goal_pulse_cycles", goal_cycles - gbase, 1);
        check_eq("goal_respawn_x", int'(FrogX), 336);
        check_eq("goal_respawn_y", int'(FrogY), 464);

        // Hit after the 4th frame of an UP hop.
        do_reset();
        keycode = 8'h1A; do_tick(1'b0);
        keycode = 8'h00;
        repeat (3) do_tick(1'b0);
        check_eq("pre_hit_y", int'(FrogY), 448);
        pulse_hit();
        do_tick(1'b0);
        check_eq("hit_freeze_y", int'(FrogY), 448);
        dead_ticks = int'(frog_dead);
        for (int i = 0; i < 30; i++) begin
            do_tick(1'b0);
            if (frog_dead) dead_ticks++;
        end
        check_eq("dead_ticks", dead_ticks, 30);
        check_eq("respawn_x", int'(FrogX), 336);
        check_eq("respawn_y", int'(FrogY), 464);
        check_eq("respawn_idle", int'(hopping | frog_dead), 0);

        // Asynchronous reset mid-hop takes effect without a Clk edge.
        keycode = 8'h00; do_tick(1'b0);
        keycode = 8'h07; do_tick(1'b0);
        keycode = 8'h00;
        repeat (2) do_tick(1'b0);
        @(posedge Clk); #3;
        Reset = 1'b0;
        #1;
        check_eq("async_x", int'(FrogX), 336);
        check_eq("async_y", int'(FrogY), 464);
        check_eq("async_s", int'(FrogS), 12);
        check_eq("async_hopping", int'(hopping), 0);
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // RIGHT, then UP on the 3rd frame and DOWN on the 5th.
        keycode = 8'h07; do_tick(1'b0);
        keycode = 8'h00; do_tick(1'b0);
        keycode = 8'h1A; do_tick(1'b0);
        keycode = 8'h00; do_tick(1'b0);
        keycode = 8'h16; do_tick(1'b0);
        keycode = 8'h00;
        repeat (20) do_tick(1'b0);
        check_eq("queue_final_x", int'(FrogX), 368);
        check_eq("queue_final_y", int'(FrogY), QEN ? 432 : 464);

        // Random keys and hits.
        do_reset();
        for (int i = 0; i < 220; i++) begin
            keycode = keys[$urandom_range(0, 5)];
            if ($urandom_range(0, 15) == 0) pulse_hit();
            repeat ($urandom_range(1, 3)) do_tick(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
